// File: rtl/fulladder_top_if.sv
// -----------------------------------------------------------------------------
// fulladder_top_if
//   Operand/result bundle for the registered ripple-carry adder.
//   Parameter:
//     SIZE      operand/sum width in bits (>= 2)
//   Signals:
//     a, b      operands (unsigned or two's complement)
//     cin       carry-in, added at bit 0
//     s         registered sum, (a + b + cin) mod 2^SIZE
//     carryout  registered carry out of the top bit (unsigned overflow)
//     overflow  registered signed overflow
//   Modports:
//     master    drives operands, observes results (bench / upstream logic)
//     slave     consumes operands, drives results (the adder)
// -----------------------------------------------------------------------------
interface fulladder_top_if #(
  parameter int SIZE = 32
);
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            cin;
  logic [SIZE-1:0] s;
  logic            carryout;
  logic            overflow;

  modport master (
    output a,
    output b,
    output cin,
    input  s,
    input  carryout,
    input  overflow
  );

  modport slave (
    input  a,
    input  b,
    input  cin,
    output s,
    output carryout,
    output overflow
  );
endinterface

// File: rtl/fulladder_top.sv
// -----------------------------------------------------------------------------
// fulladder_top
//   SIZE-bit two's-complement adder with carry-in, built as a ripple chain of
//   1-bit full-adder cells. Sum, unsigned carry-out and signed overflow are
//   registered on the rising edge of clk; one add per cycle, no handshake.
//
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   synchronous active-high reset, clears every register
//     bus   fulladder_top_if.slave  operands a/b/cin in, s/carryout/overflow out
//
//   Build option:
//     FULLADDER_IN_REG_EN  when defined, a/b/cin pass through an input
//                          register stage first (latency 2 instead of 1).
// -----------------------------------------------------------------------------
module fulladder_top #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  fulladder_top_if.slave  bus
);

  // Operands as seen by the adder chain (raw or input-registered).
  logic [SIZE-1:0] a_s;
  logic [SIZE-1:0] b_s;
  logic            cin_s;

  // Ripple chain: carry_s[i] is the carry into cell i, carry_s[SIZE] the carry out.
  logic [SIZE:0]   carry_s;
  logic [SIZE-1:0] sum_s;
  logic            co_next_s;
  logic            ov_next_s;

  // Output registers.
  logic [SIZE-1:0] s_r;
  logic            co_r;
  logic            ov_r;

`ifdef FULLADDER_IN_REG_EN
  logic [SIZE-1:0] a_r;
  logic [SIZE-1:0] b_r;
  logic            cin_r;

  // Input stage: operands registered before the adder chain, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {SIZE{1'b0}};
      b_r   <= {SIZE{1'b0}};
      cin_r <= 1'b0;
    end else begin
      a_r   <= bus.a;
      b_r   <= bus.b;
      cin_r <= bus.cin;
    end
  end

  assign a_s   = a_r;
  assign b_s   = b_r;
  assign cin_s = cin_r;
`else
  assign a_s   = bus.a;
  assign b_s   = bus.b;
  assign cin_s = bus.cin;
`endif

  // Ripple-carry chain of full-adder cells, cell i fed by carry_s[i].
  always_comb begin
    carry_s    = {(SIZE+1){1'b0}};
    sum_s      = {SIZE{1'b0}};
    carry_s[0] = cin_s;
    for (int i = 0; i < SIZE; i++) begin
      sum_s[i]     = a_s[i] ^ b_s[i] ^ carry_s[i];
      carry_s[i+1] = (a_s[i] & b_s[i]) | (carry_s[i] & (a_s[i] ^ b_s[i]));
    end
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign co_next_s = carry_s[SIZE];
  assign ov_next_s = carry_s[SIZE] ^ carry_s[SIZE-1];

  // Output stage: capture sum and flags every cycle; reset wins over new operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r  <= {SIZE{1'b0}};
      co_r <= 1'b0;
      ov_r <= 1'b0;
    end else begin
      s_r  <= sum_s;
      co_r <= co_next_s;
      ov_r <= ov_next_s;
    end
  end

  assign bus.s        = s_r;
  assign bus.carryout = co_r;
  assign bus.overflow = ov_r;

endmodule

// File: tb/tb_fulladder_top.sv
// -----------------------------------------------------------------------------
// tb_fulladder_top
//   Scoreboard bench for fulladder_top (SIZE=32). Every cycle one operand set
//   is driven on the falling edge and its expected result queued; results are
//   popped and compared once the pipeline latency has elapsed.
// -----------------------------------------------------------------------------
module tb_fulladder_top;
  localparam int SIZE = 32;
`ifdef FULLADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [SIZE-1:0] s;
    logic            co;
    logic            ov;
    int              idx;
  } exp_t;

  logic clk;
  logic rst;
  fulladder_top_if #(.SIZE(SIZE)) bus ();

  fulladder_top #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  int   n_vec;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result from wide arithmetic and sign comparison.
  function automatic exp_t model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                 input logic cin);
    exp_t e;
    logic [SIZE:0] w;
    w    = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, cin};
    e.s  = w[SIZE-1:0];
    e.co = w[SIZE];
    e.ov = (a[SIZE-1] == b[SIZE-1]) && (w[SIZE-1] != a[SIZE-1]);
    e.idx = 0;
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (q.size() >= LAT) begin
      e = q.pop_front();
      check_eq($sformatf("v%0d_s", e.idx),  {32'h0, bus.s},             {32'h0, e.s});
      check_eq($sformatf("v%0d_co", e.idx), {63'h0, bus.carryout},      {63'h0, e.co});
      check_eq($sformatf("v%0d_ov", e.idx), {63'h0, bus.overflow},      {63'h0, e.ov});
    end
  endtask

  // One cycle: compare the result due now, then drive new operands and queue their result.
  task automatic step(input logic r, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                      input logic cin);
    exp_t e;
    @(negedge clk);
    pop_check();
    rst     = r;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    if (r) begin
      // Reset flushes everything still in flight.
      for (int i = 0; i < q.size(); i++) begin
        q[i].s  = {SIZE{1'b0}};
        q[i].co = 1'b0;
        q[i].ov = 1'b0;
      end
      e.s  = {SIZE{1'b0}};
      e.co = 1'b0;
      e.ov = 1'b0;
    end else begin
      e = model(a, b, cin);
    end
    e.idx = n_vec;
    n_vec++;
    q.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_vec = 0;
    rst     = 1'b1;
    bus.a   = {SIZE{1'b0}};
    bus.b   = {SIZE{1'b0}};
    bus.cin = 1'b0;

    // Reset state with zero operands.
    step(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    step(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
    step(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    // Directed corners.
    step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step(1'b0, 32'hFFFF_FFE1, 32'hFFFF_FFE1, 1'b1);
    step(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    step(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    // Reset mid-stream with an overflowing add applied, then release.
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step(1'b0, 32'h0000_0005, 32'h0000_0003, 1'b1);
    // Reset with in-flight results already queued.
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    step(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    // Random operands.
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
    end
    // Drain the pipeline.
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      pop_check();
      bus.a   = {SIZE{1'b0}};
      bus.b   = {SIZE{1'b0}};
      bus.cin = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
